// File: rtl/bsg_concentrate_pkg.sv
// bsg_concentrate_pkg: shared width helper and slot record
// for the round-robin array concentrator.
package bsg_concentrate_pkg;

    // log2 width of an index, never narrower than one bit
    function automatic int lg(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    localparam int els_c     = 5;
    localparam int width_c   = 128;
    localparam int out_els_c = 2;

    typedef struct packed {
        logic [lg(els_c)-1:0] src_id;
        logic [width_c-1:0]   data;
    } slot_t;

endpackage

// File: rtl/bsg_array_concentrate_rr_sched_if.sv
// bsg_array_concentrate_rr_sched_if: row inputs, grants and
// output slot handshake of the round-robin concentrator.
interface bsg_array_concentrate_rr_sched_if
    import bsg_concentrate_pkg::*;
#(
    parameter int els_p     = els_c,
    parameter int width_p   = width_c,
    parameter int out_els_p = out_els_c
);
    localparam int id_w = lg(els_p);

    logic [els_p-1:0]           v_i;
    logic [els_p*width_p-1:0]   data_i;
    logic [els_p-1:0]           ready_o;
    logic [out_els_p-1:0]       v_o;
    logic [out_els_p*width_p-1:0] data_o;
    logic [out_els_p*id_w-1:0]  src_id_o;
    logic [out_els_p-1:0]       yumi_i;

    modport master (
        output v_i, data_i, yumi_i,
        input  ready_o, v_o, data_o, src_id_o
    );

    modport slave (
        input  v_i, data_i, yumi_i,
        output ready_o, v_o, data_o, src_id_o
    );

endinterface

// File: rtl/bsg_rr_pick_n.sv
// bsg_rr_pick_n: grants up to free_cnt requesters in round-robin
// order starting at ptr; purely combinational.
module bsg_rr_pick_n
    import bsg_concentrate_pkg::*;
#(
    parameter int els_p     = 5,
    parameter int out_els_p = 2,
    localparam int id_w  = lg(els_p),
    localparam int cnt_w = $clog2(out_els_p + 1)
) (
    input  logic [els_p-1:0]                req,
    input  logic [id_w-1:0]                 ptr,
    input  logic [cnt_w-1:0]                free_cnt,
    output logic [els_p-1:0]                grant,
    output logic [out_els_p-1:0][id_w-1:0]  row_idx,
    output logic [cnt_w-1:0]                n_grant,
    output logic [id_w-1:0]                 last_grant
);

    // rank each requester by scan distance from ptr; grant the lowest ranks
    always_comb begin
        int pos [els_p];
        int rank;
        int best;
        grant      = '0;
        row_idx    = '0;
        n_grant    = '0;
        last_grant = '0;
        best       = -1;
        rank       = 0;
        for (int r = 0; r < els_p; r++) begin
            pos[r] = r - int'(ptr);
            if (pos[r] < 0) pos[r] = pos[r] + els_p;
        end
        for (int r = 0; r < els_p; r++) begin
            rank = 0;
            for (int q = 0; q < els_p; q++) begin
                if (req[q] && pos[q] < pos[r]) rank = rank + 1;
            end
            if (req[r] && rank < int'(free_cnt)) begin
                grant[r] = 1'b1;
                n_grant  = n_grant + cnt_w'(1);
                for (int n = 0; n < out_els_p; n++) begin
                    if (n == rank) row_idx[n] = id_w'(r);
                end
                if (pos[r] > best) begin
                    best       = pos[r];
                    last_grant = id_w'(r);
                end
            end
        end
    end

endmodule

// File: rtl/bsg_array_concentrate_rr_sched.sv
// bsg_array_concentrate_rr_sched: round-robin scheduler moving up to
// out_els_p valid rows per cycle into registered, source-tagged slots.
module bsg_array_concentrate_rr_sched
    import bsg_concentrate_pkg::*;
#(
    parameter int els_p     = els_c,
    parameter int width_p   = width_c,
    parameter int out_els_p = out_els_c
) (
    input logic clk_i,
    input logic reset_i,
    bsg_array_concentrate_rr_sched_if.slave bus
);
    localparam int id_w  = lg(els_p);
    localparam int cnt_w = $clog2(out_els_p + 1);

    logic [els_p-1:0][width_p-1:0]     rows;
    logic [out_els_p-1:0]              v_r;
    logic [out_els_p-1:0]              free;
    logic [out_els_p-1:0]              fill;
    logic [out_els_p-1:0][width_p-1:0] data_r;
    logic [out_els_p-1:0][id_w-1:0]    src_r;
    logic [out_els_p-1:0][id_w-1:0]    fill_row;
    logic [out_els_p-1:0][id_w-1:0]    row_idx;
    logic [cnt_w-1:0]                  free_cnt;
    logic [cnt_w-1:0]                  n_grant;
    logic [els_p-1:0]                  grant;
    logic [id_w-1:0]                   ptr_r;
    logic [id_w-1:0]                   last_grant;

    assign rows = bus.data_i;
    assign free = ~v_r | bus.yumi_i;

    assign bus.ready_o  = reset_i ? '0 : grant;
    assign bus.v_o      = v_r;
    assign bus.data_o   = data_r;
    assign bus.src_id_o = src_r;

    // number of slots that can take a row this cycle
    always_comb begin
        free_cnt = '0;
        for (int j = 0; j < out_els_p; j++) begin
            free_cnt = free_cnt + cnt_w'(free[j]);
        end
    end

    bsg_rr_pick_n #(
        .els_p     (els_p),
        .out_els_p (out_els_p)
    ) pick (
        .req        (bus.v_i),
        .ptr        (ptr_r),
        .free_cnt   (free_cnt),
        .grant      (grant),
        .row_idx    (row_idx),
        .n_grant    (n_grant),
        .last_grant (last_grant)
    );

    // n-th free slot (ascending index) takes the n-th granted row
    always_comb begin
        int rank;
        fill     = '0;
        fill_row = '0;
        rank     = 0;
        for (int j = 0; j < out_els_p; j++) begin
            rank = 0;
            for (int i = 0; i < j; i++) rank = rank + int'(free[i]);
            if (free[j] && rank < int'(n_grant)) begin
                fill[j] = 1'b1;
                for (int n = 0; n < out_els_p; n++) begin
                    if (n == rank) fill_row[j] = row_idx[n];
                end
            end
        end
    end

    // slot registers: refill, clear on consume, otherwise hold
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            v_r    <= '0;
            data_r <= '0;
            src_r  <= '0;
        end else begin
            for (int j = 0; j < out_els_p; j++) begin
                if (fill[j]) begin
                    v_r[j]    <= 1'b1;
                    data_r[j] <= rows[fill_row[j]];
                    src_r[j]  <= fill_row[j];
                end else if (bus.yumi_i[j]) begin
                    v_r[j] <= 1'b0;
                end
            end
        end
    end

    // scan pointer moves just past the last granted row
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            ptr_r <= '0;
        end else if (|grant) begin
            if (int'(last_grant) == els_p - 1) ptr_r <= '0;
            else ptr_r <= last_grant + 1'b1;
        end
    end

    for (genvar j = 0; j < out_els_p; j++) begin : g_yumi_chk
        a_yumi: assert property (@(posedge clk_i) disable iff (reset_i)
            !(bus.yumi_i[j] && !v_r[j]));
    end

    for (genvar k = 0; k < els_p; k++) begin : g_hold_chk
        a_hold: assert property (@(posedge clk_i) disable iff (reset_i)
            (bus.v_i[k] && !bus.ready_o[k]) |=> bus.v_i[k]);
    end

endmodule

// File: tb/tb_bsg_array_concentrate_rr_sched.sv
// tb_bsg_array_concentrate_rr_sched: directed and random checks of the
// round-robin concentrator against a queue-based reference model.
module tb_bsg_array_concentrate_rr_sched;
    import bsg_concentrate_pkg::*;

    localparam int ELS = 5;
    localparam int W   = 128;
    localparam int OUT = 2;
    localparam int IDW = lg(ELS);

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    bsg_array_concentrate_rr_sched_if #(
        .els_p(ELS), .width_p(W), .out_els_p(OUT)
    ) bus ();

    bsg_array_concentrate_rr_sched #(
        .els_p(ELS), .width_p(W), .out_els_p(OUT)
    ) dut (
        .clk_i   (clk),
        .reset_i (reset),
        .bus     (bus)
    );

    int checks   = 0;
    int failures = 0;
    string cur_test = "";

    slot_t          m_slot [OUT];
    logic [OUT-1:0] m_v;
    int             m_ptr;
    logic [W-1:0]   row_data [ELS];
    logic [ELS-1:0] pending;
    logic [ELS-1:0] last_ready;
    int             serial = 0;
    int             outstanding [int];

    task automatic model_reset();
        m_v     = '0;
        m_ptr   = 0;
        pending = '0;
        for (int j = 0; j < OUT; j++) m_slot[j] = '0;
        outstanding.delete();
    endtask

    // one clock: drive at negedge, check grants, advance model, check slots
    task automatic run_cycle(input logic [ELS-1:0] v,
                             input logic [OUT-1:0] y_req);
        logic [OUT-1:0]     y;
        logic [ELS-1:0]     exp_ready;
        logic [OUT-1:0]     exp_v;
        logic [OUT*W-1:0]   exp_data;
        logic [OUT*IDW-1:0] exp_src;
        int free_q[$];
        int gq[$];
        int key;
        int k;
        y = y_req & m_v;
        for (int r = 0; r < ELS; r++) begin
            if (v[r] && !pending[r]) begin
                serial++;
                row_data[r] = {$urandom, $urandom, $urandom, 32'(serial)};
            end
            bus.data_i[r*W +: W] = v[r] ? row_data[r] : '0;
        end
        bus.v_i    = v;
        bus.yumi_i = y;
        #1;
        for (int j = 0; j < OUT; j++) begin
            if (!m_v[j] || y[j]) free_q.push_back(j);
        end
        for (int i = 0; i < ELS; i++) begin
            k = (m_ptr + i) % ELS;
            if (v[k] && gq.size() < free_q.size()) gq.push_back(k);
        end
        exp_ready = '0;
        foreach (gq[n]) exp_ready[gq[n]] = 1'b1;
        checks++;
        if (bus.ready_o !== exp_ready) begin
            failures++;
            $display("FAIL %s ready: got %b want %b",
                     cur_test, bus.ready_o, exp_ready);
        end
        last_ready = bus.ready_o;
        for (int j = 0; j < OUT; j++) begin
            if (y[j]) begin
                key = int'(bus.data_o[j*W +: 32]);
                checks++;
                if (!outstanding.exists(key) ||
                    outstanding[key] != int'(bus.src_id_o[j*IDW +: IDW])) begin
                    failures++;
                    $display("FAIL %s consume slot%0d: got tag %0d src %0d, not an outstanding row",
                             cur_test, j, key, bus.src_id_o[j*IDW +: IDW]);
                end else begin
                    outstanding.delete(key);
                end
            end
        end
        foreach (gq[n]) outstanding[int'(row_data[gq[n]][31:0])] = gq[n];
        pending = v & ~exp_ready;
        @(posedge clk);
        for (int j = 0; j < OUT; j++) if (y[j]) m_v[j] = 1'b0;
        foreach (gq[n]) begin
            m_v[free_q[n]]           = 1'b1;
            m_slot[free_q[n]].src_id = IDW'(gq[n]);
            m_slot[free_q[n]].data   = row_data[gq[n]];
        end
        if (gq.size() > 0) m_ptr = (gq[gq.size()-1] + 1) % ELS;
        @(negedge clk);
        for (int j = 0; j < OUT; j++) begin
            exp_v[j]               = m_v[j];
            exp_data[j*W +: W]     = m_slot[j].data;
            exp_src[j*IDW +: IDW]  = m_slot[j].src_id;
        end
        checks++;
        if (bus.v_o !== exp_v) begin
            failures++;
            $display("FAIL %s v_o: got %b want %b", cur_test, bus.v_o, exp_v);
        end
        checks++;
        if (bus.src_id_o !== exp_src) begin
            failures++;
            $display("FAIL %s src_id_o: got %h want %h",
                     cur_test, bus.src_id_o, exp_src);
        end
        checks++;
        if (bus.data_o !== exp_data) begin
            failures++;
            $display("FAIL %s data_o: got %h want %h",
                     cur_test, bus.data_o, exp_data);
        end
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        bus.v_i    = '0;
        bus.yumi_i = '0;
        bus.data_i = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        cur_test = "reset";
        do_reset();
        checks++;
        if (bus.v_o !== 2'b00 || bus.ready_o !== 5'b0) begin
            failures++;
            $display("FAIL reset_state: got v_o %b ready %b want 00 00000",
                     bus.v_o, bus.ready_o);
        end
        run_cycle(5'b00011, 2'b00);
        reset = 1'b1;
        #1;
        checks++;
        if (bus.v_o !== 2'b00 || bus.ready_o !== 5'b0 ||
            bus.data_o !== '0 || bus.src_id_o !== '0) begin
            failures++;
            $display("FAIL mid_reset: got v_o %b ready %b src %h want all zero",
                     bus.v_o, bus.ready_o, bus.src_id_o);
        end
        bus.v_i = '0;
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        run_cycle(5'b11111, 2'b00);
        checks++;
        if (last_ready !== 5'b00011) begin
            failures++;
            $display("FAIL reset_first_grant: got %b want 00011", last_ready);
        end
    endtask

    task automatic test_wrap();
        cur_test = "wrap";
        do_reset();
        run_cycle(5'b10001, 2'b00);
        checks++;
        if (last_ready !== 5'b10001) begin
            failures++;
            $display("FAIL wrap_ready: got %b want 10001", last_ready);
        end
        checks++;
        if (bus.src_id_o !== {3'd4, 3'd0}) begin
            failures++;
            $display("FAIL wrap_src: got %h want %h", bus.src_id_o, {3'd4, 3'd0});
        end
        run_cycle(5'b11111, 2'b11);
        checks++;
        if (last_ready !== 5'b00011) begin
            failures++;
            $display("FAIL wrap_ptr: got %b want 00011", last_ready);
        end
    endtask

    task automatic test_all_valid();
        logic [ELS-1:0] exp_seq [6];
        int wait_c [ELS];
        int max_wait;
        cur_test = "all_valid";
        exp_seq = '{5'b00011, 5'b01100, 5'b10001, 5'b00110, 5'b11000, 5'b00011};
        do_reset();
        max_wait = 0;
        for (int r = 0; r < ELS; r++) wait_c[r] = 0;
        for (int c = 0; c < 6; c++) begin
            run_cycle(5'b11111, 2'b11);
            checks++;
            if (last_ready !== exp_seq[c]) begin
                failures++;
                $display("FAIL all_valid_seq%0d: got %b want %b",
                         c, last_ready, exp_seq[c]);
            end
            for (int r = 0; r < ELS; r++) begin
                if (last_ready[r]) wait_c[r] = 0;
                else wait_c[r]++;
                if (wait_c[r] > max_wait) max_wait = wait_c[r];
            end
        end
        checks++;
        if (max_wait >= 3) begin
            failures++;
            $display("FAIL fairness: got wait %0d want < 3", max_wait);
        end
    endtask

    task automatic test_partial_free();
        logic [W-1:0] snap;
        cur_test = "partial_free";
        do_reset();
        run_cycle(5'b00011, 2'b00);
        snap = bus.data_o[W +: W];
        run_cycle(5'b00110, 2'b01);
        checks++;
        if (last_ready !== 5'b00100) begin
            failures++;
            $display("FAIL partial_ready: got %b want 00100", last_ready);
        end
        checks++;
        if (bus.src_id_o !== {3'd1, 3'd2} || bus.data_o[W +: W] !== snap) begin
            failures++;
            $display("FAIL partial_slots: got src %h want %h",
                     bus.src_id_o, {3'd1, 3'd2});
        end
    endtask

    task automatic test_backpressure();
        logic [OUT*W-1:0] snap;
        int n;
        cur_test = "backpressure";
        do_reset();
        run_cycle(5'b11111, 2'b00);
        snap = bus.data_o;
        for (int c = 0; c < 10; c++) begin
            run_cycle(5'b11111, 2'b00);
            checks++;
            if (last_ready !== 5'b0 || bus.data_o !== snap) begin
                failures++;
                $display("FAIL bp_hold%0d: got ready %b want 00000", c, last_ready);
            end
        end
        n = 0;
        while ((pending != 0 || m_v != 0) && n < 12) begin
            run_cycle(pending, 2'b11);
            n++;
        end
        checks++;
        if (pending != 0 || m_v != 0 || outstanding.size() != 0) begin
            failures++;
            $display("FAIL bp_drain: got %0d rows outstanding want 0",
                     outstanding.size());
        end
    endtask

    task automatic test_random();
        logic [ELS-1:0] v;
        int n;
        cur_test = "random";
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            v = pending | ELS'($urandom);
            run_cycle(v, OUT'($urandom));
        end
        n = 0;
        while ((pending != 0 || m_v != 0) && n < 20) begin
            run_cycle(pending, 2'b11);
            n++;
        end
        checks++;
        if (outstanding.size() != 0) begin
            failures++;
            $display("FAIL random_lost: got %0d rows outstanding want 0",
                     outstanding.size());
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        model_reset();
        test_reset();
        test_wrap();
        test_all_valid();
        test_partial_free();
        test_backpressure();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
